// File: rtl/vga_cam_pkg.sv
// Shared constants and types for the camera-overlay AHB write path.
// Holds AHB encodings, frame defaults, the FIFO entry layout and the error FSM states.
package vga_cam_pkg;

  localparam logic [1:0]  HTRANS_IDLE    = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ  = 2'b10;
  localparam logic [2:0]  HSIZE_WORD     = 3'b010;
  localparam logic [2:0]  HBURST_SINGLE  = 3'b000;

  localparam int          CAM_PIX_DEF    = 4096;
  localparam logic [31:0] CAM_BASE_DEF   = 32'h4001_C000;
  localparam int          FIFO_DEPTH_DEF = 8;

  typedef struct packed {
    logic sof;
    logic pix;
  } pix_entry_t;

  typedef enum logic {
    ERR_OK,
    ERR_ERR2
  } err_state_t;

endpackage

// File: rtl/cam_pix_fifo.sv
// Show-ahead synchronous FIFO of binarized pixels ({sof, pix} per entry).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cam_pix_fifo
  import vga_cam_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     push,
  input  pix_entry_t               push_data,
  input  logic                     pop,
  output pix_entry_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  pix_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_cam_ahb_writer.sv
// AHB-Lite write initiator: binarizes camera pixels, buffers them and writes one word per pixel.
// Address/data phase registers, frame index counter and a two-state ERROR response handler.
module vga_cam_ahb_writer
  import vga_cam_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = CAM_BASE_DEF,
  parameter int          CAM_PIX    = CAM_PIX_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic [7:0]  threshold,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        frame_done,
  output logic        bus_err,
  output logic        busy
);

  localparam int             IW       = $clog2(CAM_PIX);
  localparam logic [IW-1:0]  IDX_LAST = IW'(CAM_PIX - 1);

  pix_entry_t                   fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_push;

  err_state_t     err_state, err_next;
  logic           err_start;
  logic           launch;
  logic           launch_fifo;
  logic [IW-1:0]  launch_idx;

  logic           ap_valid, ap_hold, ap_pix;
  logic [IW-1:0]  ap_idx;
  logic           dp_valid, dp_pix;
  logic [IW-1:0]  dp_idx;
  logic [IW-1:0]  nxt_idx;

  assign pix_ready = !fifo_full;
  assign fifo_push = pix_valid && pix_ready;

  cam_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .push      (fifo_push),
    .push_data ('{sof: pix_sof, pix: (pix_data >= threshold)}),
    .pop       (launch_fifo),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_state <= ERR_OK;
    else        err_state <= err_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    err_next    = err_state;
    err_start   = 1'b0;
    case (err_state)
      ERR_OK:   if (dp_valid && HRESP && !HREADY) begin
                  err_start = 1'b1;
                  err_next  = ERR_ERR2;
                end
      ERR_ERR2: if (HREADY) err_next = ERR_OK;
      default:  err_next = ERR_OK;
    endcase
    // A cancelled address phase is relaunched from ap_hold ahead of the FIFO.
    launch      = enable && (ap_hold || !fifo_empty) && (!ap_valid || HREADY) && !err_start;
    launch_fifo = launch && !ap_hold;
  end

  assign launch_idx = fifo_head.sof ? '0 : nxt_idx;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid   <= 1'b0;
      ap_hold    <= 1'b0;
      ap_idx     <= '0;
      ap_pix     <= 1'b0;
      dp_valid   <= 1'b0;
      dp_idx     <= '0;
      dp_pix     <= 1'b0;
      nxt_idx    <= '0;
      frame_done <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if (err_start) begin
        ap_valid <= 1'b0;
        ap_hold  <= ap_valid || ap_hold;
      end else if (launch) begin
        ap_valid <= 1'b1;
        ap_hold  <= 1'b0;
        if (launch_fifo) begin
          ap_idx  <= launch_idx;
          ap_pix  <= fifo_head.pix;
          nxt_idx <= (launch_idx == IDX_LAST) ? '0 : launch_idx + 1'b1;
        end
      end else if (HREADY) begin
        ap_valid <= 1'b0;
      end

      if (HREADY) begin
        dp_valid <= ap_valid;
        if (ap_valid) begin
          dp_idx <= ap_idx;
          dp_pix <= ap_pix;
        end
      end

      // An errored data phase retires in ERR2 and never reports the frame end.
      frame_done <= dp_valid && HREADY && (err_state == ERR_OK) && (dp_idx == IDX_LAST);
      bus_err    <= bus_err || err_start;
    end
  end

  assign HTRANS = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE = ap_valid;
  assign HADDR  = BASE_ADDR + {{(30-IW){1'b0}}, ap_idx, 2'b00};
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HWDATA = {31'b0, dp_pix};
  assign busy   = (fifo_count != '0) || ap_valid || ap_hold || dp_valid;

endmodule

// File: tb/tb_vga_cam_ahb_writer.sv
// Self-checking bench for vga_cam_ahb_writer: queue-based model of pushed pixels and their
// expected word writes, checked every cycle, plus directed literal checks of key scenarios.
module tb_vga_cam_ahb_writer;

  localparam int          CAM_PIX = 4096;
  localparam logic [31:0] BASE    = 32'h4001_C000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  threshold = 8'h80;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_sof = 1'b0;
  logic        pix_ready;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        frame_done;
  logic        bus_err;
  logic        busy;

  vga_cam_ahb_writer dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .enable     (enable),
    .threshold  (threshold),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .HTRANS     (HTRANS),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .frame_done (frame_done),
    .bus_err    (bus_err),
    .busy       (busy)
  );

  always #5 HCLK = ~HCLK;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    return BASE + 32'(idx) * 32'd4;
  endfunction

  // Model: pixels inside the DUT awaiting an accepted address phase, plus the data phase.
  typedef struct {
    int   idx;
    logic pix;
  } exp_t;

  exp_t        ap_q[$];
  exp_t        dp;
  bit          dp_v = 0;
  int          next_idx = 0;
  bit          err_prev = 0;
  bit          err_now;
  bit          fd_exp = 0;
  bit          fd_nxt;
  bit          be_exp = 0;
  logic [1:0]  exp_htrans = 2'b00;
  logic [31:0] exp_addr;
  int          fd_count = 0;
  logic [31:0] acc_log[$];
  exp_t        pushed;

  initial begin : model_cmp
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        ap_q.delete();
        dp_v = 0; next_idx = 0; err_prev = 0; fd_exp = 0; be_exp = 0; exp_htrans = 2'b00;
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", pix_ready, 1'b1);
      end else begin
        check("htrans", HTRANS, exp_htrans);
        check("hwrite", HWRITE, HTRANS == 2'b10);
        check("hsize", HSIZE, 3'b010);
        check("hburst", HBURST, 3'b000);
        if (HTRANS == 2'b10) begin
          exp_addr = (ap_q.size() != 0) ? addr_of(ap_q[0].idx) : 32'hFFFF_FFFF;
          check("haddr", HADDR, exp_addr);
        end
        if (dp_v) check("hwdata", HWDATA, {31'b0, dp.pix});
        check("frame_done", frame_done, fd_exp);
        check("bus_err", bus_err, be_exp);
        check("busy", busy, (ap_q.size() != 0) || dp_v);
        if (ap_q.size() < 8) check("pix_ready", pix_ready, 1'b1);
        if (frame_done) fd_count++;

        err_now = dp_v && HRESP && !HREADY && !err_prev;
        fd_nxt  = 0;
        if (dp_v && HREADY) begin
          if (!err_prev && dp.idx == CAM_PIX - 1) fd_nxt = 1;
          dp_v = 0;
        end
        if (HTRANS == 2'b10 && HREADY && ap_q.size() != 0) begin
          dp   = ap_q.pop_front();
          dp_v = 1;
          acc_log.push_back(HADDR);
        end
        if (err_now)                          exp_htrans = 2'b00;
        else if (HTRANS == 2'b10 && !HREADY)  exp_htrans = 2'b10;
        else exp_htrans = (enable && ap_q.size() != 0) ? 2'b10 : 2'b00;
        be_exp   = be_exp || err_now;
        fd_exp   = fd_nxt;
        err_prev = err_now;

        if (pix_valid && pix_ready) begin
          pushed.idx = pix_sof ? 0 : next_idx;
          pushed.pix = (pix_data >= threshold);
          next_idx   = (pushed.idx + 1) % CAM_PIX;
          ap_q.push_back(pushed);
        end
      end
    end
  end

  task automatic push_pix(input logic [7:0] d, input logic [7:0] thr, input logic s);
    int n = 0;
    pix_valid = 1'b1; pix_data = d; threshold = thr; pix_sof = s;
    @(negedge HCLK);
    while (!pix_ready && n < 3000) begin
      @(negedge HCLK);
      n++;
    end
    if (!pix_ready) check("push_timeout", pix_ready, 1'b1);
    @(posedge HCLK); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy || ap_q.size() != 0 || dp_v) && n < 5000) begin
      @(negedge HCLK);
      n++;
    end
    check(name, busy, 1'b0);
    repeat (2) @(negedge HCLK);
    @(posedge HCLK); #1;
  endtask

  int          acc;
  int          fd_base;
  logic [31:0] haddr0;
  bit          stream_done;
  int          err_step;

  initial begin
    // 1: reset release, then a quiet bus
    repeat (3) @(posedge HCLK);
    #2 HRESET = 1'b0;
    check("rst_haddr", HADDR, BASE);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_buserr", bus_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); #1;
      check("idle_htrans", HTRANS, 2'b00);
      check("idle_busy", busy, 1'b0);
    end
    enable = 1'b1;

    // 2: single pixels, latency and binarization
    push_pix(8'h90, 8'h80, 1'b1);
    @(posedge HCLK); #1;
    check("t2_htrans", HTRANS, 2'b10);
    check("t2_haddr", HADDR, 32'h4001_C000);
    @(posedge HCLK); #1;
    check("t2_hwdata1", HWDATA, 32'h1);
    push_pix(8'h7F, 8'h80, 1'b0);
    @(posedge HCLK); #1;
    check("t2_haddr2", HADDR, 32'h4001_C004);
    @(posedge HCLK); #1;
    check("t2_hwdata0", HWDATA, 32'h0);
    drain("t2_drain");

    // 3: one full frame back-to-back plus the first pixel of the next
    acc_log.delete();
    fd_base = fd_count;
    for (int i = 0; i <= CAM_PIX; i++) push_pix(8'($urandom), 8'($urandom), i == 0);
    drain("t3_drain");
    check("t3_count", acc_log.size(), CAM_PIX + 1);
    if (acc_log.size() == CAM_PIX + 1) begin
      check("t3_first", acc_log[0], 32'h4001_C000);
      check("t3_last", acc_log[CAM_PIX-1], 32'h4001_FFFC);
      check("t3_wrap", acc_log[CAM_PIX], 32'h4001_C000);
    end
    check("t3_frame_done", fd_count - fd_base, 1);

    // 4a: with launches disabled the FIFO takes exactly 8 pixels
    enable = 1'b0;
    acc = 0;
    pix_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pix_data = 8'($urandom); pix_sof = (i == 0);
      @(negedge HCLK);
      if (pix_ready) acc++;
      @(posedge HCLK); #1;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    check("t4_pushes", acc, 8);
    check("t4_full", pix_ready, 1'b0);
    enable = 1'b1;
    drain("t4a_drain");

    // 4b: 12-cycle wait state in the middle of a stream
    fork
      for (int i = 0; i < 40; i++) push_pix(8'($urandom), 8'($urandom), 1'b0);
      begin
        repeat (10) @(posedge HCLK);
        #1 HREADY = 1'b0;
        haddr0 = HADDR;
        for (int i = 0; i < 12; i++) begin
          #2;
          check("t4_hold_haddr", HADDR, haddr0);
          check("t4_hold_htrans", HTRANS, 2'b10);
          @(posedge HCLK); #1;
        end
        check("t4_stall_full", pix_ready, 1'b0);
        HREADY = 1'b1;
      end
    join
    drain("t4b_drain");

    // 5: sof at pixel 100 restarts the frame without a frame_done
    acc_log.delete();
    fd_base = fd_count;
    for (int i = 0; i < 106; i++) push_pix(8'($urandom), 8'h40, (i == 0) || (i == 100));
    drain("t5_drain");
    if (acc_log.size() == 106) begin
      check("t5_before", acc_log[99], 32'h4001_C18C);
      check("t5_sof", acc_log[100], 32'h4001_C000);
    end
    check("t5_count", acc_log.size(), 106);
    check("t5_no_fd", fd_count - fd_base, 0);

    // 6: ERROR on index 5, the pending index 6 is reissued
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_pix(8'($urandom), 8'h80, i == 0);
    enable = 1'b1;
    acc = 0;
    while (!(dp_v && dp.idx == 5) && acc < 50) begin
      @(posedge HCLK); #1;
      acc++;
    end
    check("t6_reach_idx5", HTRANS, 2'b10);
    HRESP = 1'b1; HREADY = 1'b0;
    @(posedge HCLK); #1;
    check("t6_idle", HTRANS, 2'b00);
    check("t6_bus_err", bus_err, 1'b1);
    HREADY = 1'b1;
    @(posedge HCLK); #1;
    HRESP = 1'b0;
    check("t6_reissue_htrans", HTRANS, 2'b10);
    check("t6_reissue_addr", HADDR, 32'h4001_C018);
    drain("t6_drain");

    // Random traffic: stalls, errors, enable gaps, random sof and thresholds
    stream_done = 0;
    err_step = 0;
    fork
      begin
        for (int i = 0; i < 1500; i++)
          push_pix(8'($urandom), 8'($urandom), $urandom_range(0, 299) == 0);
        stream_done = 1;
      end
      while (!stream_done) begin
        @(posedge HCLK); #1;
        if (err_step == 1) begin
          HRESP = 1'b1; HREADY = 1'b1; err_step = 0;
        end else if (dp_v && $urandom_range(0, 40) == 0) begin
          HRESP = 1'b1; HREADY = 1'b0; err_step = 1;
        end else begin
          HRESP = 1'b0; HREADY = ($urandom_range(0, 3) != 0);
        end
        enable = ($urandom_range(0, 15) != 0);
      end
    join
    if (err_step == 1) begin
      @(posedge HCLK); #1;
      HRESP = 1'b1; HREADY = 1'b1;
    end
    @(posedge HCLK); #1;
    HRESP = 1'b0; HREADY = 1'b1; enable = 1'b1;
    drain("rand_drain");

    // 7: reset pulse during a wait state
    for (int i = 0; i < 3; i++) push_pix(8'($urandom), 8'h80, i == 0);
    HREADY = 1'b0;
    push_pix(8'hFF, 8'h80, 1'b0);
    push_pix(8'hFF, 8'h80, 1'b0);
    @(posedge HCLK); #3;
    HRESET = 1'b1;
    #1;
    check("t7_htrans", HTRANS, 2'b00);
    check("t7_haddr", HADDR, BASE);
    check("t7_hwrite", HWRITE, 1'b0);
    check("t7_hwdata", HWDATA, 32'h0);
    check("t7_busy", busy, 1'b0);
    check("t7_ready", pix_ready, 1'b1);
    check("t7_bus_err", bus_err, 1'b0);
    repeat (2) @(posedge HCLK);
    #2 HRESET = 1'b0; HREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge HCLK); #1;
      check("t7_after_htrans", HTRANS, 2'b00);
      check("t7_after_busy", busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", err_cnt);
    $fatal(1, "watchdog");
  end

endmodule
